// File: rtl/chan_readout_scheduler_if.sv
// ============================================================================
// Module   : chan_readout_scheduler_if
// Brief    : Fill/command/event handshake bundle for the readout scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface chan_readout_scheduler_if #(
    parameter int NCHAN = 5
);
    logic [NCHAN-1:0] chan_en_mask;
    logic             fill_valid;
    logic [23:0]      fill_num;
    logic             fill_ready;
    logic             cmd_valid;
    logic [31:0]      cmd_data;
    logic [3:0]       cmd_dest;
    logic             cmd_ready;
    logic             chan_done;
    logic             evt_valid;
    logic [23:0]      evt_fill_num;
    logic [NCHAN-1:0] evt_ok_mask;
    logic [NCHAN-1:0] evt_err_mask;
    logic             evt_ready;
    logic             busy;
    logic [15:0]      timeout_cnt;

    modport master (
        input  chan_en_mask, fill_valid, fill_num, cmd_ready, chan_done, evt_ready,
        output fill_ready, cmd_valid, cmd_data, cmd_dest, evt_valid, evt_fill_num,
               evt_ok_mask, evt_err_mask, busy, timeout_cnt
    );

    modport slave (
        output chan_en_mask, fill_valid, fill_num, cmd_ready, chan_done, evt_ready,
        input  fill_ready, cmd_valid, cmd_data, cmd_dest, evt_valid, evt_fill_num,
               evt_ok_mask, evt_err_mask, busy, timeout_cnt
    );
endinterface

`default_nettype wire

// File: rtl/chan_readout_scheduler.sv
// ============================================================================
// Module   : chan_readout_scheduler
// Brief    : Per-fill channel readout sequencer with per-channel timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module chan_readout_scheduler #(
    parameter int          NCHAN    = 5,
    parameter int          TIMEOUT  = 1023,
    parameter logic [31:0] CMD_WORD = 32'hBAADF00D
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    chan_readout_scheduler_if.master  bus
);

    localparam logic [3:0]  c_last_idx  = 4'(NCHAN - 1);
    localparam logic [15:0] c_wait_last = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIND   = 3'd1,
        S_SEND   = 3'd2,
        S_WAIT   = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t           r_state;
    logic [3:0]       r_idx;
    logic [15:0]      r_wait_cnt;
    logic [NCHAN-1:0] r_mask;
    logic [23:0]      r_fill_num;
    logic [NCHAN-1:0] r_ok;
    logic [NCHAN-1:0] r_err;
    logic [15:0]      r_timeout_cnt;
    logic             r_fill_ready;
    logic             r_busy;
    logic             r_cmd_valid;
    logic [31:0]      r_cmd_data;
    logic [3:0]       r_cmd_dest;
    logic             r_evt_valid;

    // Widen to 16 so a 4-bit index selects cleanly for any legal NCHAN.
    logic [15:0]      w_mask_ext;
    logic [15:0]      w_onehot;
    logic [NCHAN-1:0] w_idx_bit;
    logic             w_mask_bit;
    logic             w_last;
    logic             w_wait_last;

    assign w_mask_ext  = 16'(r_mask);
    assign w_onehot    = 16'd1 << r_idx;
    assign w_idx_bit   = w_onehot[NCHAN-1:0];
    assign w_mask_bit  = w_mask_ext[r_idx];
    assign w_last      = (r_idx == c_last_idx);
    assign w_wait_last = (r_wait_cnt == c_wait_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= 4'd0;
            r_wait_cnt    <= 16'd0;
            r_mask        <= '0;
            r_fill_num    <= 24'd0;
            r_ok          <= '0;
            r_err         <= '0;
            r_timeout_cnt <= 16'd0;
            r_fill_ready  <= 1'b1;
            r_busy        <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd_data    <= 32'd0;
            r_cmd_dest    <= 4'd0;
            r_evt_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.fill_valid) begin
                        r_fill_num   <= bus.fill_num;
                        r_mask       <= bus.chan_en_mask;
                        r_idx        <= 4'd0;
                        r_ok         <= '0;
                        r_err        <= '0;
                        r_fill_ready <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_FIND;
                    end
                end
                S_FIND: begin
                    if (w_mask_bit) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_data  <= CMD_WORD;
                        r_cmd_dest  <= r_idx;
                        r_state     <= S_SEND;
                    end else if (w_last) begin
                        r_evt_valid <= 1'b1;
                        r_state     <= S_REPORT;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_SEND: begin
                    if (bus.cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cmd_data  <= 32'd0;
                        r_cmd_dest  <= 4'd0;
                        r_wait_cnt  <= 16'd0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 16'd1;
                    if (bus.chan_done || w_wait_last) begin
                        // A done pulse on the timeout cycle still counts as success.
                        if (bus.chan_done) begin
                            r_ok <= r_ok | w_idx_bit;
                        end else begin
                            r_err <= r_err | w_idx_bit;
                            if (r_timeout_cnt != 16'hFFFF) begin
                                r_timeout_cnt <= r_timeout_cnt + 16'd1;
                            end
                        end
                        if (w_last) begin
                            r_evt_valid <= 1'b1;
                            r_state     <= S_REPORT;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= S_FIND;
                        end
                    end
                end
                S_REPORT: begin
                    if (bus.evt_ready) begin
                        r_evt_valid  <= 1'b0;
                        r_fill_ready <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_fill_ready <= 1'b1;
                    r_busy       <= 1'b0;
                    r_cmd_valid  <= 1'b0;
                    r_evt_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fill_ready   = r_fill_ready;
    assign bus.cmd_valid    = r_cmd_valid;
    assign bus.cmd_data     = r_cmd_data;
    assign bus.cmd_dest     = r_cmd_dest;
    assign bus.evt_valid    = r_evt_valid;
    assign bus.evt_fill_num = r_fill_num;
    assign bus.evt_ok_mask  = r_ok;
    assign bus.evt_err_mask = r_err;
    assign bus.busy         = r_busy;
    assign bus.timeout_cnt  = r_timeout_cnt;

endmodule

`default_nettype wire

// File: tb/tb_chan_readout_scheduler.sv
// ============================================================================
// Module   : tb_chan_readout_scheduler
// Brief    : Directed plus randomized fills checked against a cycle-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_chan_readout_scheduler;

    localparam int          NCHAN   = 5;
    localparam int          TIMEOUT = 8;
    localparam logic [31:0] CMD     = 32'hBAADF00D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chan_readout_scheduler_if #(.NCHAN(NCHAN)) bus ();

    chan_readout_scheduler #(
        .NCHAN   (NCHAN),
        .TIMEOUT (TIMEOUT),
        .CMD_WORD(CMD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_tcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk_reset_values();
        chk("rst_fill_ready", 32'(bus.fill_ready), 32'd1);
        chk("rst_cmd_valid",  32'(bus.cmd_valid), 32'd0);
        chk("rst_cmd_data",   bus.cmd_data, 32'd0);
        chk("rst_cmd_dest",   32'(bus.cmd_dest), 32'd0);
        chk("rst_evt_valid",  32'(bus.evt_valid), 32'd0);
        chk("rst_evt_fill",   32'(bus.evt_fill_num), 32'd0);
        chk("rst_evt_ok",     32'(bus.evt_ok_mask), 32'd0);
        chk("rst_evt_err",    32'(bus.evt_err_mask), 32'd0);
        chk("rst_busy",       32'(bus.busy), 32'd0);
        chk("rst_tcnt",       32'(bus.timeout_cnt), 32'd0);
    endtask

    // dly[n]: cycles after command accept at which chan_done pulses; > TIMEOUT means never.
    task automatic run_fill(input logic [NCHAN-1:0] mask, input logic [23:0] fnum,
                            input int dly[NCHAN], input int stall[NCHAN], input int hold);
        logic [NCHAN-1:0] eok;
        logic [NCHAN-1:0] eerr;
        int t, nxt, e, a, w;
        eok  = '0;
        eerr = '0;
        bus.chan_done = 1'b1;
        step();
        bus.chan_done = 1'b0;
        chk("idle_fill_ready", 32'(bus.fill_ready), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        bus.fill_valid   = 1'b1;
        bus.fill_num     = fnum;
        bus.chan_en_mask = mask;
        step();
        cyc = 1;
        bus.fill_valid   = 1'b0;
        bus.fill_num     = 24'($urandom);
        bus.chan_en_mask = NCHAN'($urandom);
        chk("acc_fill_ready", 32'(bus.fill_ready), 32'd0);
        chk("acc_busy", 32'(bus.busy), 32'd1);
        t   = 1;
        nxt = 0;
        for (int n = 0; n < NCHAN; n++) begin
            if (mask[n]) begin
                e = t + (n - nxt) + 1;
                while (cyc < e - 1) step();
                chk("pre_cmd_valid", 32'(bus.cmd_valid), 32'd0);
                step();
                chk("cmd_valid", 32'(bus.cmd_valid), 32'd1);
                chk("cmd_data", bus.cmd_data, CMD);
                chk("cmd_dest", 32'(bus.cmd_dest), 32'(n));
                for (int s = 0; s < stall[n]; s++) begin
                    step();
                    chk("stall_valid", 32'(bus.cmd_valid), 32'd1);
                    chk("stall_data", bus.cmd_data, CMD);
                    chk("stall_dest", 32'(bus.cmd_dest), 32'(n));
                end
                bus.cmd_ready = 1'b1;
                a = cyc;
                step();
                bus.cmd_ready = 1'b0;
                chk("wait_cmd_valid", 32'(bus.cmd_valid), 32'd0);
                chk("wait_cmd_data", bus.cmd_data, 32'd0);
                w = (dly[n] < TIMEOUT) ? dly[n] : TIMEOUT;
                for (int i = 0; i < w; i++) begin
                    bus.chan_done = (i + 1 == dly[n]);
                    step();
                    bus.chan_done = 1'b0;
                end
                if (dly[n] <= TIMEOUT) begin
                    eok[n] = 1'b1;
                end else begin
                    eerr[n] = 1'b1;
                    if (exp_tcnt < 65535) exp_tcnt++;
                end
                t   = a + w + 1;
                nxt = n + 1;
            end
        end
        e = t + NCHAN - nxt;
        while (cyc < e - 1) step();
        if (cyc == e - 1) begin
            chk("pre_evt_valid", 32'(bus.evt_valid), 32'd0);
            step();
        end
        chk("evt_valid", 32'(bus.evt_valid), 32'd1);
        chk("evt_fill_num", 32'(bus.evt_fill_num), 32'(fnum));
        chk("evt_ok", 32'(bus.evt_ok_mask), 32'(eok));
        chk("evt_err", 32'(bus.evt_err_mask), 32'(eerr));
        chk("evt_tcnt", 32'(bus.timeout_cnt), 32'(exp_tcnt));
        chk("rep_fill_ready", 32'(bus.fill_ready), 32'd0);
        chk("rep_busy", 32'(bus.busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            bus.chan_done = 1'($urandom);
            step();
            chk("hold_evt_valid", 32'(bus.evt_valid), 32'd1);
            chk("hold_ok", 32'(bus.evt_ok_mask), 32'(eok));
            chk("hold_err", 32'(bus.evt_err_mask), 32'(eerr));
            chk("hold_fill", 32'(bus.evt_fill_num), 32'(fnum));
            chk("hold_fill_ready", 32'(bus.fill_ready), 32'd0);
        end
        bus.chan_done = 1'b0;
        bus.evt_ready = 1'b1;
        step();
        bus.evt_ready = 1'b0;
        chk("post_evt_valid", 32'(bus.evt_valid), 32'd0);
        chk("post_fill_ready", 32'(bus.fill_ready), 32'd1);
        chk("post_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int dly[NCHAN];
        int stl[NCHAN];
        bus.chan_en_mask = '0;
        bus.fill_valid   = 1'b0;
        bus.fill_num     = 24'd0;
        bus.cmd_ready    = 1'b0;
        bus.chan_done    = 1'b0;
        bus.evt_ready    = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_values();
        rst = 1'b0;

        // Two channels, prompt responses.
        dly = '{3, 3, 3, 3, 3};
        stl = '{0, 0, 0, 0, 0};
        run_fill(5'b00101, 24'h000123, dly, stl, 0);

        // Channel 1 never responds.
        dly = '{3, 99, 3, 3, 3};
        run_fill(5'b00011, 24'h00ABCD, dly, stl, 1);

        // Back-pressure on the first command.
        dly = '{2, 2, 2, 2, 2};
        stl = '{5, 0, 0, 0, 0};
        run_fill(5'b10001, 24'h555555, dly, stl, 0);

        // Nothing enabled.
        stl = '{0, 0, 0, 0, 0};
        run_fill(5'b00000, 24'hFFFFFF, dly, stl, 2);

        // Done pulse on the timeout cycle, long event stall.
        dly = '{TIMEOUT, 1, TIMEOUT + 1, 1, 1};
        run_fill(5'b00101, 24'h0F0F0F, dly, stl, 10);

        for (int f = 0; f < 20; f++) begin
            for (int n = 0; n < NCHAN; n++) begin
                dly[n] = int'($urandom_range(1, TIMEOUT + 2));
                stl[n] = int'($urandom_range(0, 2));
            end
            run_fill(NCHAN'($urandom), 24'($urandom), dly, stl, int'($urandom_range(0, 3)));
        end

        // Abort in the middle of a channel wait.
        bus.fill_valid   = 1'b1;
        bus.fill_num     = 24'h777777;
        bus.chan_en_mask = 5'b00001;
        step();
        bus.fill_valid = 1'b0;
        step();
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;
        step();
        chk("abort_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_reset_values();
        @(negedge clk);
        rst = 1'b0;
        exp_tcnt = 0;
        dly = '{4, 99, 2, 2, 2};
        stl = '{1, 0, 0, 0, 0};
        run_fill(5'b00011, 24'h000042, dly, stl, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/chan_readout_scheduler.md
# chan_readout_scheduler

Sequences per-fill readout of the digitizer channels. It accepts a fill number from the trigger FIFO and walks the enabled-channel mask in ascending order. For each enabled channel it issues a readout command on the shared channel TX FIFO and waits, with a timeout, for the datapath to report that channel's last word. It then hands a per-fill summary (responding/timed-out channels) to the DAQ event builder for header/trailer formation.

## Interface
Parameters:
- NCHAN, 5: number of channels; legal range 1..16.
- TIMEOUT, 1023: maximum cycles spent waiting for one channel; legal range 2..65535.
- CMD_WORD, 32'hBAADF00D: readout command word sent to each channel.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- chan_en_mask  in  NCHAN  enabled channels; sampled only when a fill is accepted.
- fill_valid  in  1  fill number available.
- fill_num  in  24  fill number.
- fill_ready  out  1  fill accepted when fill_valid && fill_ready.
- cmd_valid  out  1  command valid to channel TX FIFO.
- cmd_data  out  32  command word; equals CMD_WORD while cmd_valid, else 0.
- cmd_dest  out  4  target channel index while cmd_valid, else 0.
- cmd_ready  in  1  TX FIFO accepts the command.
- chan_done  in  1  one-cycle pulse: datapath forwarded the current channel's last word.
- evt_valid  out  1  fill summary valid.
- evt_fill_num  out  24  latched fill number.
- evt_ok_mask  out  NCHAN  channels that completed.
- evt_err_mask  out  NCHAN  channels that timed out.
- evt_ready  in  1  event builder consumes the summary.
- busy  out  1  high in every state except IDLE.
- timeout_cnt  out  16  total timeouts since reset; saturates at 16'hFFFF.

## Operation
- States: IDLE, FIND, SEND, WAIT, REPORT.
- IDLE:
  - fill_ready=1.
  - On fill_valid, latch fill_num and chan_en_mask, set idx=0, clear ok/err masks, go to FIND.
- FIND: examines one channel per cycle.
  - mask[idx]=1 → SEND.
  - mask[idx]=0 and idx<NCHAN-1 → idx+1, stay in FIND.
  - mask[idx]=0 and idx=NCHAN-1 → REPORT.
- SEND:
  - cmd_valid=1, cmd_data=CMD_WORD, cmd_dest=idx; all three held stable until cmd_ready.
  - On cmd_ready → WAIT, with the wait counter cleared to 0.
- WAIT: the wait counter increments every cycle.
  - chan_done=1 → set ok[idx].
  - Otherwise, counter==TIMEOUT-1 → set err[idx] and increment timeout_cnt (saturating).
  - Either event → FIND with idx+1, or REPORT if idx=NCHAN-1.
- REPORT:
  - evt_valid=1; evt_* outputs are registered and stable.
  - On evt_ready → IDLE.
- chan_done outside WAIT is ignored.
- chan_done and timeout in the same WAIT cycle: chan_done wins; ok bit set, no error counted.
- All-zero mask: FIND scans all NCHAN indices, then REPORT with ok=err=0.
- chan_en_mask changes after acceptance have no effect on the current fill.

## Timing
- Reset values:
  - State IDLE, so fill_ready=1.
  - cmd_valid=0, cmd_data=0, cmd_dest=0.
  - evt_valid=0, evt_fill_num=0, evt_ok_mask=0, evt_err_mask=0.
  - busy=0, timeout_cnt=0, idx=0.
- Reset mid-fill aborts immediately. The fill is lost and any in-flight command is not completed.
- Fill accepted at edge k: FIND occupies cycle k+1. If the first enabled channel is n, cmd_valid rises at cycle k+2+n.
- Command accepted at edge j: chan_done sampled from cycle j+1 onward. Timeout exits WAIT TIMEOUT cycles after entry.
- After the last channel's done/timeout edge, evt_valid is high on the next cycle.
- One fill in flight at a time; fill_ready stays low until evt_ready is sampled in REPORT.

## Test plan
- Mask=5'b00101, fill 0x000123, cmd_ready tied 1, chan_done 3 cycles after each command → commands to dest 0 then 2; evt_fill_num=0x000123, ok=00101, err=0, timeout_cnt=0.
- Mask=5'b00011, chan_done never asserted for ch1, TIMEOUT=8 → ch1 WAIT lasts exactly 8 cycles; ok=00001, err=00010, timeout_cnt=1.
- cmd_ready low for 5 cycles on ch0 → cmd_valid/cmd_data/cmd_dest stable for all 6 cycles; single accept.
- Mask=0 → no cmd_valid; evt_valid at cycle k+1+NCHAN with ok=err=0. Also drive chan_done during IDLE/REPORT → no effect.
- chan_done on the timeout cycle → ok bit set, err clear, timeout_cnt unchanged. Hold evt_ready low 10 cycles → evt outputs stable and fill_ready=0 throughout.
- rst pulsed mid-WAIT → all outputs return to reset values; the next fill starts cleanly from channel 0.
